// File: rtl/divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first, N bits.
// Latency: end_div first rises N cycles after the edge that accepts start.
// Backpressure: results are held in DONE for as long as start stays high.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset (priority over everything)
//   start      level request, sampled only in IDLE
//   A, B       dividend / divisor, captured on the accepting edge
//   end_div    result valid, high only while in DONE
//   quociente  quotient (registered, held until the next result load)
//   resto      remainder (registered, held until the next result load)
//   div_zero   set with the results when the captured divisor was zero
//
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands
// (quotient truncates toward zero, remainder takes the sign of A).
// Without it the divider is unsigned only and no sign logic exists.
module divider #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         end_div,
  output logic [N-1:0] quociente,
  output logic [N-1:0] resto,
  output logic         div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(N);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_dvd;   // dividend bits shift out MSB first, quotient bits shift in
  logic [N-1:0]  r_dvs;
  logic [N-1:0]  r_rem;
  logic          r_bz;    // captured divisor was zero
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_res;
  logic          r_dz;

  logic [N-1:0]  w_a_cap;
  logic [N-1:0]  w_b_cap;
  logic [N:0]    w_shift;
  logic [N:0]    w_diff;
  logic          w_borrow;
  logic [N-1:0]  w_rem_nxt;
  logic [N-1:0]  w_quo_nxt;
  logic [N-1:0]  w_quo_fin;
  logic [N-1:0]  w_res_fin;

`ifdef DIVIDER_SIGNED_EN
  logic r_a_neg;
  logic r_q_neg;

  // The datapath always works on magnitudes; the most negative value maps
  // onto itself, which is still its correct unsigned magnitude.
  assign w_a_cap = A[N-1] ? -A : A;
  assign w_b_cap = B[N-1] ? -B : B;

  // A zero divisor keeps the raw all-ones quotient; the remainder path
  // restores the sign of A, which reproduces A exactly.
  assign w_quo_fin = (r_q_neg && !r_bz) ? -w_quo_nxt : w_quo_nxt;
  assign w_res_fin = r_a_neg ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_neg <= 1'b0;
      r_q_neg <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_a_neg <= A[N-1];
      r_q_neg <= A[N-1] ^ B[N-1];
    end
  end
`else
  assign w_a_cap   = A;
  assign w_b_cap   = B;
  assign w_quo_fin = w_quo_nxt;
  assign w_res_fin = w_rem_nxt;
`endif

  // One restoring step. The partial remainder is always < divisor, so the
  // shifted value is < 2*divisor and the (N+1)-bit difference's top bit is
  // exactly the borrow. With a zero divisor the step never borrows, which
  // yields an all-ones quotient and leaves the dividend as the remainder.
  assign w_shift   = {r_rem, r_dvd[N-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_borrow  = w_diff[N] & ~r_bz;
  assign w_rem_nxt = w_borrow ? w_shift[N-1:0] : w_diff[N-1:0];
  assign w_quo_nxt = {r_dvd[N-2:0], ~w_borrow};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_bz    <= 1'b0;
      r_quo   <= '0;
      r_res   <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= w_a_cap;
            r_dvs   <= w_b_cap;
            r_bz    <= (B == '0);
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_quo   <= w_quo_fin;
            r_res   <= w_res_fin;
            r_dz    <= r_bz;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!start) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign end_div   = (r_state == S_DONE);
  assign quociente = r_quo;
  assign resto     = r_res;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_divider.sv
module tb_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        end_div;
  logic [31:0] quociente;
  logic [31:0] resto;
  logic        div_zero;

  int n_chk = 0;
  int n_err = 0;

  divider #(.N(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .A         (A),
    .B         (B),
    .end_div   (end_div),
    .quociente (quociente),
    .resto     (resto),
    .div_zero  (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Present operands with start high and pass the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Count edges after acceptance until end_div. mode 0: start held for two
  // edges in total; mode 1: start kept high; mode 2: operands changed and
  // start pulsed in the middle of the calculation.
  task automatic wait_done(input int mode, output int lat);
    lat = 0;
    while (!end_div && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (mode != 1 && lat == 1) start = 1'b0;
      if (mode == 2 && lat == 5) begin
        A     = ~A;
        B     = 32'h3;
        start = 1'b1;
      end
      if (mode == 2 && lat == 6) start = 1'b0;
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v, input int mode);
    int lat;
    start_op(v.a, v.b);
    wait_done(mode, lat);
    chk({nm, " latency"}, 32'(lat), 32'd32);
    chk({nm, " quociente"}, quociente, v.q);
    chk({nm, " resto"}, resto, v.r);
    chk({nm, " div_zero"}, {31'd0, div_zero}, {31'd0, v.dz});
    if (mode != 1) begin
      // start already low: FSM leaves DONE on the next edge, results stay put.
      @(posedge clock);
      #1;
      chk({nm, " end_div low after DONE"}, {31'd0, end_div}, 32'd0);
      chk({nm, " quociente held"}, quociente, v.q);
    end
  endtask

  initial begin
    vec_t v;
    int   seen;
    int   lat;

`ifdef DIVIDER_SIGNED_EN
    vecs[0] = '{32'h12345678, 32'h00001234, 32'h00010004, 32'h00000DA8, 1'b0};
    vecs[1] = '{32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[3] = '{32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0};
    vecs[4] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{32'h00123045, 32'h00000000, 32'hFFFFFFFF, 32'h00123045, 1'b1};
    vecs[6] = '{32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};
    vecs[7] = '{32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0};
`else
    vecs[0] = '{32'h12345678, 32'h00001234, 32'h00010004, 32'h00000DA8, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0};
    vecs[3] = '{32'h00123045, 32'h00000000, 32'hFFFFFFFF, 32'h00123045, 1'b1};
    vecs[4] = '{32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0};
    vecs[5] = '{32'h00000005, 32'h00000009, 32'h00000000, 32'h00000005, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};
    vecs[7] = '{32'h80000000, 32'h80000001, 32'h00000000, 32'h80000000, 1'b0};
`endif

    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset end_div", {31'd0, end_div}, 32'd0);
    chk("reset quociente", quociente, 32'd0);
    chk("reset resto", resto, 32'd0);
    chk("reset div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i], 0);

    // Divide by zero with start held: end_div stays up until start drops.
    v = '{32'h00123045, 32'h00000000, 32'hFFFFFFFF, 32'h00123045, 1'b1};
    run_vec("dz_hold", v, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("dz_hold end_div held %0d", k), {31'd0, end_div}, 32'd1);
    end
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("dz_hold end_div drops", {31'd0, end_div}, 32'd0);
    @(posedge clock);
    #1;
    chk("dz_hold idle", {31'd0, end_div}, 32'd0);
    chk("dz_hold resto held", resto, 32'h00123045);

    // Reset 10 cycles into CALC with start low.
    start_op(32'h12345678, 32'h00001234);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midreset end_div", {31'd0, end_div}, 32'd0);
    chk("midreset quociente", quociente, 32'd0);
    chk("midreset resto", resto, 32'd0);
    chk("midreset div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (end_div) seen++;
    end
    chk("midreset no end_div", 32'(seen), 32'd0);
    run_vec("after_reset", vecs[0], 0);

    // Operand changes and a start pulse during CALC are ignored.
    v = '{32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0};
    run_vec("disturb", v, 2);

    // Reset with start high wins; start kept high begins a new op right after.
    @(negedge clock);
    A     = 32'h00000064;
    B     = 32'h00000007;
    start = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_start end_div", {31'd0, end_div}, 32'd0);
    chk("rst_start quociente", quociente, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    wait_done(0, lat);
    chk("rst_start latency", 32'(lat), 32'd32);
    chk("rst_start quociente", quociente, 32'h0000000E);
    chk("rst_start resto", resto, 32'h00000002);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
